// File: rtl/frame_reader_if.sv
// RAM read port and output pixel stream of frame_reader.
// The sof/eol markers exist only when FRAME_READER_POS_EN is defined.
interface frame_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 17
);
    logic              ram_en_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_data_i;
    logic              pix_valid_o;
    logic              pix_ready_i;
    logic [DATA_W-1:0] pix_data_o;
`ifdef FRAME_READER_POS_EN
    logic              pix_sof_o;
    logic              pix_eol_o;
`endif

    modport master (
        output ram_en_o, ram_addr_o, pix_valid_o, pix_data_o,
`ifdef FRAME_READER_POS_EN
        output pix_sof_o, pix_eol_o,
`endif
        input  ram_data_i, pix_ready_i
    );

    modport slave (
        input  ram_en_o, ram_addr_o, pix_valid_o, pix_data_o,
`ifdef FRAME_READER_POS_EN
        input  pix_sof_o, pix_eol_o,
`endif
        output ram_data_i, pix_ready_i
    );
endinterface

// File: rtl/frame_reader.sv
// Streams one frame from a 1-cycle-latency pixel RAM through a 2-entry skid buffer.
// Define FRAME_READER_POS_EN to add the sof/eol position markers.
module frame_reader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned WIDTH     = 320,
    parameter int unsigned HEIGHT    = 240,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    frame_reader_if.master bus
);
    localparam int unsigned N     = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
`ifdef FRAME_READER_POS_EN
    logic [$clog2(WIDTH+1)-1:0]  col_q, col_d;
    logic [$clog2(HEIGHT+1)-1:0] row_q, row_d;
`endif

    logic       pop;
    logic       issue;
    logic [2:0] credit;

    always_comb begin
        pop    = (occ_q != 2'd0) && bus.pix_ready_i;
        // Occupancy projected to the end of next cycle must leave room for this read.
        credit = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue  = (state_q == S_RUN) && (rd_cnt_q < CNT_W'(N)) && (credit <= 3'd1);

        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        inflight_d = issue;
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ram_addr_d = ram_addr_q;
`ifdef FRAME_READER_POS_EN
        col_d      = col_q;
        row_d      = row_q;
`endif

        if (issue) begin
            rd_cnt_d   = rd_cnt_q + 1'b1;
            ram_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt_q);
        end

        unique case ({inflight_q, pop})
            2'b10: begin
                if (occ_q == 2'd0) head_d = bus.ram_data_i;
                else               tail_d = bus.ram_data_i;
                occ_d = occ_q + 1'b1;
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - 1'b1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    head_d = bus.ram_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.ram_data_i;
                end
            end
            default: ;
        endcase

        if (pop && (out_cnt_q < CNT_W'(N))) begin
            out_cnt_d = out_cnt_q + 1'b1;
`ifdef FRAME_READER_POS_EN
            if (col_q == ($clog2(WIDTH+1))'(WIDTH - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
`endif
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_RUN;
                    rd_cnt_d   = '0;
                    out_cnt_d  = '0;
                    occ_d      = '0;
                    inflight_d = 1'b0;
`ifdef FRAME_READER_POS_EN
                    col_d      = '0;
                    row_d      = '0;
`endif
                end
            end
            S_RUN: begin
                if (pop && (out_cnt_q == CNT_W'(N - 1))) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            out_cnt_q  <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            ram_addr_q <= '0;
`ifdef FRAME_READER_POS_EN
            col_q      <= '0;
            row_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            ram_addr_q <= ram_addr_d;
`ifdef FRAME_READER_POS_EN
            col_q      <= col_d;
            row_q      <= row_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(inflight_q && !pop && (occ_q == 2'd2)));
    end

    assign busy_o          = (state_q == S_RUN);
    assign done_o          = (state_q == S_DONE);
    assign bus.ram_en_o    = issue;
    assign bus.ram_addr_o  = ram_addr_d;
    assign bus.pix_valid_o = (occ_q != 2'd0);
    assign bus.pix_data_o  = head_q;
`ifdef FRAME_READER_POS_EN
    assign bus.pix_sof_o   = (occ_q != 2'd0) && (col_q == '0) && (row_q == '0);
    assign bus.pix_eol_o   = (occ_q != 2'd0) && (col_q == ($clog2(WIDTH+1))'(WIDTH - 1));
`endif
endmodule

// File: tb/tb_frame_reader.sv
// Scoreboard bench for frame_reader on a 4x2 frame stored at RAM address 16.
module tb_frame_reader;
    localparam int unsigned DW = 8, W = 4, H = 2, AW = 17, BASE = 16, N = W * H;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eol;
        int         cyc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready = 1'b0;
    logic busy, done;
    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] ram_q = '0;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0, n_err = 0;
    exp_t q[$];

    frame_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    frame_reader #(.DATA_W(DW), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.ram_en_o) ram_q <= mem[bus.ram_addr_o[5:0]];
    assign bus.ram_data_i  = ram_q;
    assign bus.pix_ready_i = ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] outs();
        logic [31:0] v;
        v = {3'b000, busy, done, bus.ram_en_o, bus.ram_addr_o, bus.pix_valid_o, bus.pix_data_o};
`ifdef FRAME_READER_POS_EN
        v[31] = bus.pix_sof_o;
        v[30] = bus.pix_eol_o;
`endif
        return v;
    endfunction

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic       stall_v = 1'b0;
    logic [7:0] stall_d;
    logic       stall_sof, stall_eol;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                chk("hold_valid", 32'(bus.pix_valid_o), 32'd1);
                chk("hold_data", 32'(bus.pix_data_o), 32'(stall_d));
`ifdef FRAME_READER_POS_EN
                chk("hold_sof", 32'(bus.pix_sof_o), 32'(stall_sof));
                chk("hold_eol", 32'(bus.pix_eol_o), 32'(stall_eol));
`endif
            end
            if (bus.pix_valid_o && bus.pix_ready_i) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_pixel: got %0d expected none", bus.pix_data_o);
                end else begin
                    e = q.pop_front();
                    chk("pix_data", 32'(bus.pix_data_o), 32'(e.d));
`ifdef FRAME_READER_POS_EN
                    chk("pix_sof", 32'(bus.pix_sof_o), 32'(e.sof));
                    chk("pix_eol", 32'(bus.pix_eol_o), 32'(e.eol));
`endif
                    if (e.cyc >= 0) chk("pix_cycle", cyc, 32'(e.cyc));
                end
            end
            stall_v   = bus.pix_valid_o && !bus.pix_ready_i;
            stall_d   = bus.pix_data_o;
`ifdef FRAME_READER_POS_EN
            stall_sof = bus.pix_sof_o;
            stall_eol = bus.pix_eol_o;
`else
            stall_sof = 1'b0;
            stall_eol = 1'b0;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; start is sampled at the next edge (E0).
    task automatic start_frame(input bit timed);
        int c0;
        c0 = int'(cyc) + 1;
        for (int k = 0; k < int'(N); k++)
            q.push_back('{8'(k + 10), (k == 0), ((k % int'(W)) == int'(W) - 1),
                          timed ? c0 + 2 + k : -1});
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("e0_ram_en", 32'(bus.ram_en_o), 32'd1);
        chk("e0_ram_addr", 32'(bus.ram_addr_o), 32'd16);
        chk("e0_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int exp_cyc);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            if (exp_cyc >= 0) chk("done_cycle", cyc, 32'(exp_cyc));
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_valid", 32'(bus.pix_valid_o), 32'd0);
            chk("done_queue_empty", 32'(q.size()), 32'd0);
            tick();
            chk("done_pulse_len", 32'(done), 32'd0);
        end
    endtask

    task automatic wait_pix(input logic [7:0] d);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.pix_valid_o && (bus.pix_data_o == d)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("pix_presented", 32'(seen), 32'd1);
    endtask

    initial begin
        int c0;
        bit done_seen;
        for (int a = 0; a < 64; a++) mem[a] = (a >= 16 && a < 24) ? 8'(a - 6) : 8'hEE;

        // Reset held: start toggling must have no effect.
        for (int i = 0; i < 4; i++) begin
            tick();
            start = ~start;
            #1;
            chk("reset_outs", outs(), 32'd0);
        end
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_outs", outs(), 32'd0);
        end

        // Full rate with cycle-accurate expectations.
        c0 = int'(cyc) + 1;
        start_frame(1'b1);
        wait_done(c0 + int'(N) + 2);

        // Backpressure: stall on pixel 12 for 5 cycles, then on pixel 13 for 2.
        start_frame(1'b0);
        wait_pix(8'd12);
        ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_ram_en", 32'(bus.ram_en_o), 32'd0);
            tick();
        end
        ready = 1'b1;
        tick();
        wait_pix(8'd13);
        ready = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
`ifdef FRAME_READER_POS_EN
            chk("stall_eol", 32'(bus.pix_eol_o), 32'd1);
`endif
            chk("stall13_data", 32'(bus.pix_data_o), 32'd13);
            tick();
        end
        ready = 1'b1;
        wait_done(-1);

        // Mid-frame start is ignored; back-to-back restart after done.
        start_frame(1'b0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(-1);
        start_frame(1'b1);
        wait_done(-1);

        // Asynchronous reset while pixel 13 is pending.
        start_frame(1'b0);
        wait_pix(8'd13);
        ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", outs(), 32'd0);
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy || bus.pix_valid_o) done_seen = 1'b1;
        end
        chk("no_done_after_reset", 32'(done_seen), 32'd0);
        start_frame(1'b1);
        wait_done(-1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/frame_reader.md
# frame_reader

Streams one stored frame out of a synchronous single-port pixel RAM to the image-processing stage as a valid/ready pixel stream. It sits directly upstream of the processing core and replaces ad-hoc address/delay counting with a credit-controlled read pipeline. A 2-entry skid buffer absorbs the RAM read latency, so the block sustains one pixel per cycle and tolerates arbitrary backpressure.

## Interface
- DATA_W, 8: pixel width in bits.
- WIDTH, 320: pixels per line.
- HEIGHT, 240: lines per frame; N = WIDTH*HEIGHT pixels per frame.
- ADDR_W, 17: RAM address width; BASE_ADDR + N must not exceed 2**ADDR_W.
- BASE_ADDR, 0: RAM address of pixel 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  frame start request; sampled only in IDLE.
- busy_o  out  1  high from the start edge until the done pulse.
- done_o  out  1  one-cycle pulse after the last pixel handshake.
- ram_en_o  out  1  RAM read enable.
- ram_addr_o  out  ADDR_W  RAM read address.
- ram_data_i  in  DATA_W  RAM read data; valid one cycle after ram_en_o.
- pix_valid_o  out  1  output pixel valid.
- pix_ready_i  in  1  downstream ready.
- pix_data_o  out  DATA_W  output pixel.
- pix_sof_o, pix_eol_o  out  1 each  frame-start and line-end markers; present only with FRAME_READER_POS_EN.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE -> RUN: start_i=1 at a clock edge. This clears rd_cnt, out_cnt, the buffer and the in-flight flag.
- RUN -> DONE: on the handshake (pix_valid_o && pix_ready_i) of pixel N-1.
- DONE -> IDLE: unconditional after one cycle. done_o=1 during the DONE cycle.
- start_i is ignored in RUN and DONE.
- Read issue (RUN only):
  - ram_en_o=1 when rd_cnt < N and (occ + inflight - pop) <= 1.
  - occ is the buffer occupancy (0..2), inflight means a read was issued last cycle, and pop is the handshake this cycle.
  - ram_addr_o = BASE_ADDR + rd_cnt. rd_cnt increments on every issue.
- Return path: a read issued in cycle t has ram_data_i valid in cycle t+1. That data is written to the buffer at the end of cycle t+1.
- Buffer:
  - 2-entry FIFO; pix_data_o comes from the head register.
  - pix_valid_o = (occ != 0).
  - A simultaneous write and pop keeps occ unchanged.
  - The credit rule guarantees the buffer never overflows. Overflow is a design error; assert it in simulation.
- Handshake rules:
  - Once pix_valid_o is raised, pix_valid_o and pix_data_o hold stable until pix_ready_i=1.
  - pix_ready_i must not affect pix_valid_o combinationally.
- out_cnt increments per handshake and stops at N.
- ram_addr_o holds its last value when ram_en_o=0.
- Outputs in IDLE: ram_en_o, pix_valid_o and busy_o are 0.

## Timing
- Reset values: busy_o=0, done_o=0, ram_en_o=0, ram_addr_o=0, pix_valid_o=0, pix_data_o=0, pix_sof_o=0, pix_eol_o=0. All internal counters and the FSM are cleared.
- Reset takes effect immediately on rst_ni falling, including mid-frame. The in-progress frame is discarded with no done_o.
- Start latency:
  - start_i sampled at edge E0.
  - ram_en_o=1 with address BASE_ADDR during cycle E0..E1.
  - pix_valid_o=1 from E2.
- Throughput: with pix_ready_i held at 1, one pixel per cycle. The frame completes N+2 cycles after E0, and done_o is high during the following cycle.
- Backpressure: with pix_ready_i=0, ram_en_o drops within one cycle. At most 2 pixels are buffered.
- N=1 is legal: one read, one pixel, then done.

## Configuration
- FRAME_READER_POS_EN defined:
  - The block keeps col/row counters on the output side. col wraps at WIDTH-1 and row then increments.
  - pix_sof_o=1 only with pixel 0.
  - pix_eol_o=1 when col == WIDTH-1.
  - Both markers are qualified by pix_valid_o and held stable under a stall like pix_data_o.
- FRAME_READER_POS_EN undefined: the markers, their ports and the counters are absent; everything else is identical.

## Test plan
- Reset: hold rst_ni=0 and toggle start_i -> every output stays 0; release reset -> no activity until start_i.
- Full rate: WIDTH=4, HEIGHT=2, BASE_ADDR=16, RAM[16+k]=k+10, pix_ready_i=1, start at E0 -> pixels 10..17 on consecutive cycles from E2; done_o high exactly one cycle after the pixel-17 handshake; busy_o falls with it.
- Backpressure: same frame, pix_ready_i=0 for 5 cycles after pixel 12 is presented -> pixel 12 is held stable, ram_en_o is 0 once 2 pixels are buffered, and the output sequence is 10..17 with no loss or duplication.
- Start handling: pulse start_i mid-frame -> ignored, exactly 8 pixels. Start again after done -> the frame restarts at address 16 with pixel 10.
- Async reset: assert rst_ni=0 asynchronously while pixel 13 is pending -> all outputs 0 before the next edge and no done_o. A new start after release streams 10..17.
- With FRAME_READER_POS_EN: pix_sof_o=1 only on pixel 10; pix_eol_o=1 on pixels 13 and 17 and held through the stall.
